// File: rtl/sync_fifo_flags.sv
// sync_fifo_flags: single-clock FIFO with occupancy count, threshold flags, sticky error flags and optional FWFT read
// Flags and count come straight from the registered pointers, so they track accepted accesses with no lag.
module sync_fifo_flags #(
    parameter int DATA_WIDTH = 8,
    parameter int DATA_DEPTH = 16,
    parameter int AF_LEVEL = 12,
    parameter int AE_LEVEL = 4,
    parameter int FWFT = 0
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            wr_en,
    input  logic [DATA_WIDTH-1:0]           data_in,
    input  logic                            rd_en,
    output logic [DATA_WIDTH-1:0]           data_out,
    output logic                            full,
    output logic                            empty,
    output logic                            almost_full,
    output logic                            almost_empty,
    output logic [$clog2(DATA_DEPTH):0]     count,
    output logic                            overflow,
    output logic                            underflow,
    input  logic                            clr_err
);
    localparam int AW = $clog2(DATA_DEPTH);
    localparam logic [AW:0] DEPTH = (AW+1)'(DATA_DEPTH);
    localparam logic [AW:0] AF = (AW+1)'(AF_LEVEL);
    localparam logic [AW:0] AE = (AW+1)'(AE_LEVEL);
    logic [DATA_WIDTH-1:0] mem [DATA_DEPTH];
    logic [DATA_WIDTH-1:0] dout_q;
    logic [AW:0] wr_ptr, rd_ptr;
    logic rd_acc, wr_acc;
    assign count = wr_ptr - rd_ptr;
    assign full = count == DEPTH;
    assign empty = count == '0;
    assign almost_full = count >= AF;
    assign almost_empty = count <= AE;
    assign rd_acc = rd_en & ~empty;
    assign wr_acc = wr_en & (~full | rd_acc);
    assign data_out = FWFT != 0 ? mem[rd_ptr[AW-1:0]] : dout_q;
    always_ff @(posedge clk) begin
        if (wr_acc && !rst) mem[wr_ptr[AW-1:0]] <= data_in;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            dout_q <= '0;
            overflow <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
            if (rd_acc) begin
                rd_ptr <= rd_ptr + 1'b1;
                dout_q <= mem[rd_ptr[AW-1:0]];
            end
            // a fresh error in the clearing cycle wins over clr_err
            overflow <= (overflow & ~clr_err) | (wr_en & ~wr_acc);
            underflow <= (underflow & ~clr_err) | (rd_en & ~rd_acc);
        end
    end
endmodule
